// File: rtl/gshare_bpred_ras.sv
// Fetch-stage next-PC predictor: gshare direction table, tagged BTB with branch kind, circular RAS.
// Lookup is combinational; GHR/RAS advance speculatively on a fetch hit, AGEX trains and repairs.
module gshare_bpred_ras #(
   parameter int DBITS       = 32,
   parameter int HIST_BITS   = 8,
   parameter int BTB_ENTRIES = 32,
   parameter int RAS_DEPTH   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 pred_valid_i,
   input  logic [DBITS-1:0]     pred_pc_i,
   output logic                 pred_taken_o,
   output logic [DBITS-1:0]     pred_target_o,
   output logic [HIST_BITS-1:0] pred_index_o,
   output logic [HIST_BITS-1:0] pred_hist_o,
   input  logic                 upd_valid_i,
   input  logic [DBITS-1:0]     upd_pc_i,
   input  logic [DBITS-1:0]     upd_target_i,
   input  logic                 upd_taken_i,
   input  logic [1:0]           upd_kind_i,
   input  logic [HIST_BITS-1:0] upd_index_i,
   input  logic [HIST_BITS-1:0] upd_hist_i,
   input  logic                 upd_mispred_i
);

   localparam int BTB_IW = $clog2(BTB_ENTRIES);
   localparam int TAG_W  = DBITS - BTB_IW - 2;
   localparam int RAS_IW = $clog2(RAS_DEPTH);
   localparam int PHT_N  = 1 << HIST_BITS;

   localparam logic [1:0] K_COND = 2'b00;
   localparam logic [1:0] K_CALL = 2'b10;
   localparam logic [1:0] K_RET  = 2'b11;

   logic [HIST_BITS-1:0]   ghr;
   logic [1:0]             pht [PHT_N];
   logic [BTB_ENTRIES-1:0] btb_vld;
   logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
   logic [DBITS-1:0]       btb_tgt [BTB_ENTRIES];
   logic [1:0]             btb_kind [BTB_ENTRIES];
   logic [DBITS-1:0]       ras [RAS_DEPTH];
   logic [RAS_IW-1:0]      ras_ptr;
   logic [RAS_IW:0]        ras_cnt;

   logic [HIST_BITS-1:0] idx;
   logic [BTB_IW-1:0]    set;
   logic [TAG_W-1:0]     tag;
   logic                 hit;
   logic [1:0]           kind;
   logic [DBITS-1:0]     pc_next;
   logic [DBITS-1:0]     ras_top;
   logic                 taken;
   logic [DBITS-1:0]     target;

   assign idx     = pred_pc_i[HIST_BITS+1:2] ^ ghr;
   assign set     = pred_pc_i[BTB_IW+1:2];
   assign tag     = pred_pc_i[DBITS-1:BTB_IW+2];
   assign hit     = btb_vld[set] && (btb_tag[set] == tag);
   assign kind    = btb_kind[set];
   assign pc_next = pred_pc_i + DBITS'(4);
   assign ras_top = ras[ras_ptr - RAS_IW'(1)];

   always_comb begin
      taken  = 1'b0;
      target = pc_next;
      if (hit) begin
         if (kind == K_COND) taken = pht[idx][1];
         else                taken = 1'b1;
         if (taken) begin
            if (kind == K_RET && ras_cnt != '0) target = ras_top;
            else                                target = btb_tgt[set];
         end
      end
   end

   assign pred_taken_o  = taken;
   assign pred_target_o = target;
   assign pred_index_o  = idx;
   assign pred_hist_o   = ghr;

   // A mispredict redirect wins over the speculative update of the same cycle.
   logic spec_fire, repair, push, pop;
   logic [HIST_BITS-1:0] ghr_nxt;

   assign spec_fire = pred_valid_i && !upd_mispred_i && hit;
   assign repair    = upd_valid_i && upd_mispred_i;
   assign push      = spec_fire && kind == K_CALL;
   assign pop       = spec_fire && kind == K_RET && ras_cnt != '0;

   always_comb begin
      ghr_nxt = ghr;
      if (repair) begin
         if (upd_kind_i == K_COND) ghr_nxt = {upd_hist_i[HIST_BITS-2:0], upd_taken_i};
         else                      ghr_nxt = upd_hist_i;
      end else if (spec_fire && kind == K_COND) begin
         ghr_nxt = {ghr[HIST_BITS-2:0], taken};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ghr     <= '0;
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else begin
         ghr <= ghr_nxt;
         if (push) begin
            ras_ptr <= ras_ptr + RAS_IW'(1);
            if (ras_cnt != (RAS_IW+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (RAS_IW+1)'(1);
         end else if (pop) begin
            ras_ptr <= ras_ptr - RAS_IW'(1);
            ras_cnt <= ras_cnt - (RAS_IW+1)'(1);
         end
      end
   end

   // A full stack wraps, overwriting the oldest return address.
   always_ff @(posedge clk) begin
      if (reset && push) ras[ras_ptr] <= pc_next;
   end

   // Training from AGEX.
   logic [BTB_IW-1:0] u_set;
   logic [TAG_W-1:0]  u_tag;
   logic              pht_wr, btb_wr;
   logic [1:0]        ctr, ctr_nxt;
   logic              unused_upd_lsb;

   assign u_set          = upd_pc_i[BTB_IW+1:2];
   assign u_tag          = upd_pc_i[DBITS-1:BTB_IW+2];
   assign pht_wr         = upd_valid_i && upd_kind_i == K_COND;
   assign btb_wr         = upd_valid_i && (upd_taken_i || upd_kind_i != K_COND);
   assign ctr            = pht[upd_index_i];
   assign unused_upd_lsb = ^upd_pc_i[1:0];

   always_comb begin
      ctr_nxt = ctr;
      if (upd_taken_i && ctr != 2'b11)       ctr_nxt = ctr + 2'd1;
      else if (!upd_taken_i && ctr != 2'b00) ctr_nxt = ctr - 2'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      end else if (pht_wr) begin
         pht[upd_index_i] <= ctr_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)      btb_vld        <= '0;
      else if (btb_wr) btb_vld[u_set] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset && btb_wr) begin
         btb_tag[u_set]  <= u_tag;
         btb_tgt[u_set]  <= upd_target_i;
         btb_kind[u_set] <= upd_kind_i;
      end
   end

endmodule
